// File: rtl/monolith_arbiter_if.sv
// Request/response bundle between the Monolith hash requesters and the arbiter.
// Modport slave is the arbiter side and modport master is the requester/consumer side.
interface monolith_arbiter_if #(
   parameter int NREQ = 2
) ();
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*31-1:0] req_in1;
   logic [NREQ*31-1:0] req_in2;
   logic [NREQ-1:0]    req_mode;
   logic               resp_valid;
   logic               resp_ready;
   logic [30:0]        resp_data;
   logic [IDW-1:0]     resp_id;
   logic               resp_err;

   modport slave (
      input  req_valid, req_in1, req_in2, req_mode, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id, resp_err
   );

   modport master (
      output req_valid, req_in1, req_in2, req_mode, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id, resp_err
   );
endinterface

// File: rtl/monolith_arbiter.sv
// Round-robin arbiter sharing one Monolith hash core between NREQ requesters.
// Optional RUN watchdog: define MONOLITH_ARB_WATCHDOG_EN (abort after TIMEOUT RUN cycles).
module monolith_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   monolith_arbiter_if.slave bus,
   output logic              core_go,
   output logic [30:0]       core_in1,
   output logic [30:0]       core_in2,
   output logic              core_mode,
   input  logic              core_valid,
   input  logic [30:0]       core_out,
   output logic [1:0]        dbg_state
);
   localparam int IDW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("monolith_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] grant_idx;
   logic           grant_any;
   logic [30:0]    sel_in1, sel_in2;
   logic           sel_mode;
   logic [30:0]    lat_in1, lat_in2;
   logic           lat_mode;
   logic [30:0]    resp_data_q;
   logic [IDW-1:0] resp_id_q;
   logic           run_done;
   logic           accept;

`ifdef MONOLITH_ARB_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] wd_cnt;
   logic           run_timeout;
   logic           resp_err_q;
`endif

   // Round-robin search: indices above last_grant first, then wrap to the low ones.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      sel_in1   = '0;
      sel_in2   = '0;
      sel_mode  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_any && i > int'(last_grant) && bus.req_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = IDW'(i);
            sel_in1   = bus.req_in1[i*31 +: 31];
            sel_in2   = bus.req_in2[i*31 +: 31];
            sel_mode  = bus.req_mode[i];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_any && i <= int'(last_grant) && bus.req_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = IDW'(i);
            sel_in1   = bus.req_in1[i*31 +: 31];
            sel_in2   = bus.req_in2[i*31 +: 31];
            sel_mode  = bus.req_mode[i];
         end
      end
   end

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // req_ready is a one-hot strobe raised only in IDLE; resp_valid holds in DONE until resp_ready.
   assign accept = (state == IDLE) && !reset && grant_any;

   always_comb begin
      state_nxt = state;
      run_done  = 1'b0;
`ifdef MONOLITH_ARB_WATCHDOG_EN
      run_timeout = 1'b0;
`endif
      case (state)
         IDLE: if (grant_any) state_nxt = LOAD;
         LOAD: state_nxt = RUN;
         RUN: begin
            if (core_valid) begin
               run_done  = 1'b1;
               state_nxt = DONE;
            end
`ifdef MONOLITH_ARB_WATCHDOG_EN
            else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
               run_timeout = 1'b1;
               state_nxt   = DONE;
            end
`endif
         end
         DONE: if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      if (accept) bus.req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= IDW'(NREQ - 1);
         lat_in1     <= '0;
         lat_in2     <= '0;
         lat_mode    <= 1'b0;
         resp_data_q <= '0;
         resp_id_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            lat_in1   <= sel_in1;
            lat_in2   <= sel_in2;
            lat_mode  <= sel_mode;
            resp_id_q <= grant_idx;
         end
         if (run_done) resp_data_q <= core_out;
`ifdef MONOLITH_ARB_WATCHDOG_EN
         if (run_timeout) resp_data_q <= '0;
`endif
         if (state == DONE && bus.resp_ready) last_grant <= resp_id_q;
      end
   end

`ifdef MONOLITH_ARB_WATCHDOG_EN
   // Counter is zero on the first RUN cycle and counts RUN cycles already spent.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt     <= '0;
         resp_err_q <= 1'b0;
      end else begin
         if (state == LOAD)     wd_cnt <= '0;
         else if (state == RUN) wd_cnt <= wd_cnt + 1'b1;
         if (run_done)          resp_err_q <= 1'b0;
         else if (run_timeout)  resp_err_q <= 1'b1;
      end
   end
   assign bus.resp_err = resp_err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

   assign core_go        = (state == RUN);
   assign core_in1       = lat_in1;
   assign core_in2       = lat_mode ? lat_in2 : 31'd0;
   assign core_mode      = lat_mode;
   assign bus.resp_valid = (state == DONE);
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_id    = resp_id_q;
   assign dbg_state      = state;
endmodule

// File: tb/tb_monolith_arbiter.sv
// Bench for monolith_arbiter: transaction-level model checked every cycle plus directed vectors.
// Watchdog scenarios run only when MONOLITH_ARB_WATCHDOG_EN is defined.
module tb_monolith_arbiter;
   localparam int NREQ    = 2;
   localparam int TIMEOUT = 8;
`ifdef MONOLITH_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        core_go, core_mode, core_valid;
   logic [30:0] core_in1, core_in2, core_out;
   logic [1:0]  dbg_state;

   monolith_arbiter_if #(.NREQ(NREQ)) bus ();

   monolith_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .core_go    (core_go),
      .core_in1   (core_in1),
      .core_in2   (core_in2),
      .core_mode  (core_mode),
      .core_valid (core_valid),
      .core_out   (core_out),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [30:0] core_fn(logic [30:0] a, logic [30:0] b, logic m);
      return m ? (a * 31'd3 + b) : (a ^ 31'h2AAAAAAA);
   endfunction

   // Core stand-in: result appears after core_lat cycles of core_go, reset whenever core_go is low.
   int core_lat   = 4;
   bit core_never = 1'b0;
   bit spur       = 1'b0;
   int core_cnt   = 0;
   always @(posedge clk) core_cnt <= core_go ? core_cnt + 1 : 0;
   assign core_valid = spur | (core_go & ~core_never & (core_cnt == core_lat - 1));
   assign core_out   = spur ? 31'h1234 : core_fn(core_in1, core_in2, core_mode);

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic timeout_fail(string name);
      n_checks++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_req(int r, logic [30:0] a, logic [30:0] b, logic m);
      bus.req_in1[r*31 +: 31] = a;
      bus.req_in2[r*31 +: 31] = b;
      bus.req_mode[r]         = m;
   endtask

   // Model state: one outstanding transaction, its age in cycles, and the last served id.
   bit          m_busy = 1'b0;
   int          m_t    = 0;
   int          m_last = NREQ - 1;
   int          m_id   = 0;
   logic [30:0] m_in1, m_in2;
   logic        m_mode;
   int          m_lat  = 0;
   bit          m_never = 1'b0;
   int          glog[$];

   task automatic wait_idle(int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!m_busy) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      if (!ok) timeout_fail("wait_idle");
   endtask

   task automatic wait_resp(string name, int start, int budget, output int k);
      k = -1;
      for (int i = start; i < start + budget; i++) begin
         if (bus.resp_valid) begin
            k = i;
            break;
         end
         tick(1);
      end
      if (k < 0) timeout_fail(name);
   endtask

   always @(negedge clk) begin : compare
      int              pick;
      int              eff;
      bit              err;
      bit              exp_go, exp_rv;
      logic [NREQ-1:0] exp_rdy;
      logic [30:0]     exp_data;
      if (reset) begin
         check("ready_in_reset", bus.req_ready, '0);
         m_busy = 1'b0;
         m_last = NREQ - 1;
      end else begin
         pick = -1;
         if (!m_busy)
            for (int k = 1; k <= NREQ; k++)
               if (pick < 0 && bus.req_valid[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
         exp_rdy = '0;
         if (pick >= 0) exp_rdy[pick] = 1'b1;
         eff = m_lat;
         err = 1'b0;
         if (WD && (m_never || m_lat > TIMEOUT)) begin
            eff = TIMEOUT;
            err = 1'b1;
         end
         exp_go   = m_busy && m_t >= 2 && m_t <= 1 + eff;
         exp_rv   = m_busy && m_t >= 2 + eff;
         exp_data = err ? 31'd0 : core_fn(m_in1, m_in2, m_mode);
         check("req_ready", bus.req_ready, exp_rdy);
         check("core_go", core_go, exp_go);
         check("resp_valid", bus.resp_valid, exp_rv);
         if (exp_go) begin
            check("core_in1", core_in1, m_in1);
            check("core_in2", core_in2, m_mode ? m_in2 : 31'd0);
            check("core_mode", core_mode, m_mode);
         end
         if (exp_rv) begin
            check("resp_data", bus.resp_data, exp_data);
            check("resp_id", bus.resp_id, m_id);
            check("resp_err", bus.resp_err, err);
         end
         if (pick >= 0) begin
            glog.push_back(pick);
            m_busy  = 1'b1;
            m_t     = 1;
            m_id    = pick;
            m_in1   = bus.req_in1[pick*31 +: 31];
            m_in2   = bus.req_in2[pick*31 +: 31];
            m_mode  = bus.req_mode[pick];
            m_lat   = core_lat;
            m_never = core_never;
         end else if (m_busy) begin
            if (exp_rv && bus.resp_ready) begin
               m_busy = 1'b0;
               m_last = m_id;
            end else begin
               m_t++;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      int start;
      int exp_g[4] = '{0, 1, 0, 1};
      bus.req_valid  = '0;
      bus.req_in1    = '0;
      bus.req_in2    = '0;
      bus.req_mode   = '0;
      bus.resp_ready = 1'b1;
      tick(2);

      check("rst_req_ready", bus.req_ready, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_err", bus.resp_err, 0);
      check("rst_core_go", core_go, 0);
      check("rst_resp_data", bus.resp_data, 0);
      check("rst_resp_id", bus.resp_id, 0);
      check("rst_core_in1", core_in1, 0);
      check("rst_core_in2", core_in2, 0);
      check("rst_core_mode", core_mode, 0);
      reset = 1'b0;

      // Single hash from requester 0, core latency 10; this cycle is cycle 0.
      core_lat = 10;
      set_req(0, 31'h12345678, 31'h55, 1'b0);
      bus.req_valid = 2'b01;
      #1;
      check("t1_ready_c0", bus.req_ready, 2'b01);
      tick(1);
      bus.req_valid = '0;
      tick(4);
      check("t1_go_c5", core_go, 1);
      check("t1_in2_zero", core_in2, 0);
      check("t1_in1", core_in1, 31'h12345678);
      wait_resp("t1_resp", 5, 40, k);
      check("t1_latency", k, 12);
      check("t1_data", bus.resp_data, 31'h389EFCD2);
      check("t1_id", bus.resp_id, 0);
      tick(1);

      // Compress from requester 1.
      core_lat = 3;
      set_req(1, 31'd5, 31'd7, 1'b1);
      bus.req_valid = 2'b10;
      tick(1);
      bus.req_valid = '0;
      wait_resp("t2_resp", 1, 40, k);
      check("t2_data", bus.resp_data, 31'd22);
      check("t2_id", bus.resp_id, 1);
      tick(1);

      // Fairness after reset: both requesters keep asking.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      set_req(0, 31'h0ABC, 31'd0, 1'b0);
      set_req(1, 31'd1, 31'd2, 1'b1);
      bus.req_valid = 2'b11;
      start = glog.size();
      for (int i = 0; i < 200 && glog.size() < start + 4; i++) tick(1);
      bus.req_valid = '0;
      if (glog.size() >= start + 4) begin
         for (int i = 0; i < 4; i++) check("fair_grant", glog[start+i], exp_g[i]);
      end else begin
         timeout_fail("fair_grants");
      end
      wait_idle(60);

      // Spurious core_valid while idle must not produce a response.
      spur = 1'b1;
      tick(2);
      spur = 1'b0;

      // Backpressure with both requesters pending and junk core_valid during DONE.
      bus.resp_ready = 1'b0;
      core_lat = 2;
      set_req(0, 31'h3333, 31'd0, 1'b0);
      bus.req_valid = 2'b11;
      tick(1);
      wait_resp("bp_resp", 1, 40, k);
      check("bp_latency", k, 4);
      spur = 1'b1;
      tick(20);
      spur = 1'b0;
      check("bp_still_valid", bus.resp_valid, 1);
      check("bp_data", bus.resp_data, 31'h2AAA9999);
      check("bp_no_ready", bus.req_ready, 0);
      bus.resp_ready = 1'b1;
      tick(1);
      check("bp_next_grant", bus.req_ready, 2'b10);
      tick(1);
      bus.req_valid = '0;
      wait_idle(40);

      // Serve requester 0 so that last grant points at 0 before the mid-RUN reset.
      core_lat = 1;
      bus.req_valid = 2'b01;
      tick(1);
      bus.req_valid = '0;
      wait_idle(40);

      core_lat = 20;
      set_req(1, 31'h77, 31'h11, 1'b1);
      bus.req_valid = 2'b10;
      tick(1);
      bus.req_valid = '0;
      tick(4);
      check("mr_go_c5", core_go, 1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mr_go_low", core_go, 0);
      check("mr_no_resp", bus.resp_valid, 0);
      core_lat = 2;
      bus.req_valid = 2'b11;
      #1;
      check("mr_prio0", bus.req_ready, 2'b01);
      tick(1);
      bus.req_valid = '0;
      wait_idle(40);

`ifdef MONOLITH_ARB_WATCHDOG_EN
      // Core never finishes: abort after TIMEOUT RUN cycles.
      core_never = 1'b1;
      set_req(0, 31'h42, 31'd0, 1'b0);
      bus.req_valid = 2'b01;
      tick(1);
      bus.req_valid = '0;
      wait_resp("wd_resp", 1, 40, k);
      check("wd_latency", k, 10);
      check("wd_err", bus.resp_err, 1);
      check("wd_data", bus.resp_data, 0);
      tick(1);
      core_never = 1'b0;
      wait_idle(20);

      // Core result lands on the timeout cycle: the result wins.
      core_lat = TIMEOUT;
      bus.req_valid = 2'b01;
      tick(1);
      bus.req_valid = '0;
      wait_resp("wd_tie_resp", 1, 40, k);
      check("wd_tie_err", bus.resp_err, 0);
      check("wd_tie_data", bus.resp_data, 31'h2AAAAAE8);
      tick(1);
      wait_idle(20);
`endif

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/monolith_arbiter.md
MONOLITH_ARBITER -- requirements
Module: monolith_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing one Monolith hash core (2..8).
REQ-002 Parameter TIMEOUT, default 64: maximum RUN cycles before abort (used only with the watchdog build option).
REQ-003 Clock and reset: clk, rising edge; reset, synchronous, active-high.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NREQ  per-requester request pending.
REQ-007 req_ready  out  NREQ  one-hot accept strobe.
REQ-008 req_in1  in  NREQ*31  first operand per requester; requester i occupies bits [31i+30:31i].
REQ-009 req_in2  in  NREQ*31  second operand per requester, compress only.
REQ-010 req_mode  in  NREQ  0 = hash, 1 = compress.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  response consumed.
REQ-013 resp_data  out  31  hash result.
REQ-014 resp_id  out  $clog2(NREQ)  index of the served requester.
REQ-015 resp_err  out  1  watchdog abort flag.
REQ-016 core_go  out  1  core enable; low holds the core in reset.
REQ-017 core_in1 / core_in2 / core_mode  out  31/31/1  core operands.
REQ-018 core_valid / core_out  in  1/31  core done flag and result word 0.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-020 IDLE: if any req_valid is high, the arbiter SHALL grant round-robin, starting the search at last_grant+1 modulo NREQ, and assert req_ready[grant] combinationally in that same cycle.
REQ-021 On acceptance the arbiter SHALL latch in1, in2, mode and id, then go to LOAD; req_ready SHALL be zero in all states other than IDLE.
REQ-022 LOAD: the arbiter SHALL hold core_go=0 and drive the latched operands for exactly 1 cycle, then go to RUN.
REQ-023 RUN: the arbiter SHALL hold core_go=1 and stable operands until core_valid=1; it SHALL then capture core_out into resp_data and go to DONE.
REQ-024 core_go SHALL deassert in DONE.
REQ-025 core_in2 SHALL be driven as 0 when the latched mode is 0.
REQ-026 DONE: the arbiter SHALL hold resp_valid=1 with stable resp_data, resp_id and resp_err until resp_ready=1.
REQ-027 On that handshake edge the arbiter SHALL update last_grant to resp_id and return to IDLE; a new grant is possible on the next cycle.
REQ-028 A req_valid that arrives or drops outside IDLE SHALL be ignored; no new grant SHALL be issued before the DONE handshake.
REQ-029 A core_valid seen in IDLE, LOAD or DONE SHALL be ignored.
REQ-030 Request-to-response latency SHALL be 1 (LOAD) + core latency + 1 cycle.

Reset
REQ-031 Under reset the FSM SHALL go to IDLE and last_grant SHALL be NREQ-1, so requester 0 has first priority.
REQ-032 Under reset req_ready, resp_valid, resp_err, core_go, resp_data, resp_id and all latched operands SHALL be 0.
REQ-033 Reset asserted in any state, including mid-RUN, SHALL abort the operation with no response issued and core_go low on the next cycle.

Configuration
REQ-034 With MONOLITH_ARB_WATCHDOG_EN defined, a counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-035 With MONOLITH_ARB_WATCHDOG_EN defined, if the counter reaches TIMEOUT without core_valid, the arbiter SHALL go to DONE with resp_err=1, resp_data=0 and core_go=0.
REQ-036 If core_valid and timeout occur in the same cycle, core_valid SHALL win and resp_err SHALL be 0.
REQ-037 Without MONOLITH_ARB_WATCHDOG_EN, resp_err SHALL be tied to 0, RUN SHALL wait indefinitely, and the counter SHALL be absent.

Verification
REQ-038 Single hash: requester 0 sends in1=0x12345678, mode=0, core model latency 10 -> req_ready[0] in cycle 0, core_in2=0, resp_valid at cycle 12, resp_id=0, resp_data equals model output.
REQ-039 Compress: requester 1 sends in1=5, in2=7, mode=1 -> core_in1=5, core_in2=7, core_mode=1 throughout RUN; resp_id=1.
REQ-040 Fairness: both requesters hold req_valid for 4 transactions -> grants 0,1,0,1.
REQ-041 Backpressure: resp_ready held low for 20 cycles -> resp_valid and resp_data stable and no new req_ready; grant follows the cycle after resp_ready=1.
REQ-042 Reset mid-RUN at cycle 5 -> by the next cycle core_go=0 and resp_valid=0; requester 0 has priority afterwards.
REQ-043 Watchdog build, TIMEOUT=8, core never asserts valid -> resp_valid with resp_err=1 and resp_data=0 after 8 RUN cycles.
